seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_hex_decode.sv | 16 +
 rtl/seg_scan.sv | 149 ++++++++++++++
 tb/tb_seg_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions and
// the active-high hex glyph table (bit7=a .. bit1=g, bit0=dp).
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Entry n sits at HEX_SEGS[n]; listed from F down to 0.
  localparam logic [15:0][7:0] HEX_SEGS = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder; output is active-high with the
// decimal point spliced into its bit position.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern         = HEX_SEGS[nibble];
    pattern[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with double-buffered display data,
// leading-zero suppression, per-digit blanking and blinking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic                    pending,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig
);

  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_reg;
  logic [DIG_W-1:0] dig_reg;
  logic [FRM_W-1:0] frame_reg;
  logic             phase_reg;
  logic             div_wrap;
  logic             frame_wrap;

  logic                  pending_reg;
  logic [VAL_W-1:0]      pend_value_reg, disp_value_reg;
  logic [NUM_DIGITS-1:0] pend_dp_reg,    disp_dp_reg;
  logic [NUM_DIGITS-1:0] pend_blank_reg, disp_blank_reg;
  logic [NUM_DIGITS-1:0] pend_blink_reg, disp_blink_reg;
  logic                  pend_lz_reg,    disp_lz_reg;

  assign div_wrap   = (div_reg == LAST_DIV);
  assign frame_wrap = div_wrap && (dig_reg == LAST_DIG);
  assign pending    = pending_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg   <= '0;
      dig_reg   <= '0;
      frame_reg <= '0;
      phase_reg <= 1'b1;
    end else begin
      div_reg <= div_wrap ? '0 : div_reg + DIV_W'(1);
      if (div_wrap)
        dig_reg <= (dig_reg == LAST_DIG) ? '0 : dig_reg + DIG_W'(1);
      if (frame_wrap) begin
        if (frame_reg == LAST_FRM) begin
          frame_reg <= '0;
          phase_reg <= ~phase_reg;
        end else begin
          frame_reg <= frame_reg + FRM_W'(1);
        end
      end
    end
  end

  // Display data only changes at the frame boundary, so a frame never mixes
  // old and new digits; a load on that same cycle queues behind the swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg    <= 1'b0;
      pend_value_reg <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '0;
      pend_blink_reg <= '0;
      pend_lz_reg    <= 1'b0;
      disp_value_reg <= '0;
      disp_dp_reg    <= '0;
      disp_blank_reg <= '0;
      disp_blink_reg <= '0;
      disp_lz_reg    <= 1'b0;
    end else begin
      if (frame_wrap && pending_reg) begin
        disp_value_reg <= pend_value_reg;
        disp_dp_reg    <= pend_dp_reg;
        disp_blank_reg <= pend_blank_reg;
        disp_blink_reg <= pend_blink_reg;
        disp_lz_reg    <= pend_lz_reg;
      end
      if (load) begin
        pend_value_reg <= value;
        pend_dp_reg    <= dp_mask;
        pend_blank_reg <= blank_mask;
        pend_blink_reg <= blink_mask;
        pend_lz_reg    <= lz_en;
        pending_reg    <= 1'b1;
      end else if (frame_wrap) begin
        pending_reg <= 1'b0;
      end
    end
  end

  logic [3:0]            nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] nib_zero;
  logic [NUM_DIGITS-1:0] suppress;

  // A digit is suppressed when it and every digit above it are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nibs[gi]     = disp_value_reg[4*gi +: 4];
    assign nib_zero[gi] = (disp_value_reg[4*gi +: 4] == 4'h0);
    if (gi == 0) begin : g_lsd
      assign suppress[gi] = 1'b0;
    end else begin : g_upper
      assign suppress[gi] = disp_lz_reg && (&nib_zero[NUM_DIGITS-1:gi]);
    end
  end

  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_dark;
  logic [7:0] cur_pattern;

  always_comb begin
    cur_nib  = nibs[dig_reg];
    cur_dp   = disp_dp_reg[dig_reg];
    cur_dark = disp_blank_reg[dig_reg] | suppress[dig_reg]
             | (disp_blink_reg[dig_reg] & ~phase_reg);
  end

  seg_hex_decode u_decode (
    .nibble  (cur_nib),
    .dp      (cur_dp),
    .pattern (cur_pattern)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_seg <= 8'hFF;
      o_dig <= ~NUM_DIGITS'(1);
    end else begin
      o_seg <= cur_dark ? 8'hFF : ~cur_pattern;
      o_dig <= ~(NUM_DIGITS'(1) << dig_reg);
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomised and directed bench for seg_scan, compared cycle by cycle against
// a model that derives scan position and blink phase from elapsed cycles.
module tb_seg_scan;

  localparam int ND  = 8;
  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int FRAME_CYC = ND * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [31:0]   value;
  logic [7:0]    dp_mask;
  logic [7:0]    blank_mask;
  logic [7:0]    blink_mask;
  logic          lz_en;
  logic          pending;
  logic [7:0]    o_seg;
  logic [7:0]    o_dig;

  always #5 clk = ~clk;

  seg_scan #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .lz_en      (lz_en),
    .pending    (pending),
    .o_seg      (o_seg),
    .o_dig      (o_dig)
  );

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  blink;
    logic        lz;
  } buf_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   k     = 0;
  buf_t m_disp;
  buf_t m_pend;
  bit   m_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%02h want=%02h", tag, k, got, want);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hFC;  4'h1: return 8'h60;  4'h2: return 8'hDA;  4'h3: return 8'hF2;
      4'h4: return 8'h66;  4'h5: return 8'hB6;  4'h6: return 8'hBE;  4'h7: return 8'hE0;
      4'h8: return 8'hFE;  4'h9: return 8'hF6;  4'hA: return 8'hEE;  4'hB: return 8'h3E;
      4'hC: return 8'h9C;  4'hD: return 8'h7A;  4'hE: return 8'h9E;  default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input buf_t b, input int d, input bit lit);
    logic [7:0] p;
    if (b.blank[d]) return 8'hFF;
    if (b.blink[d] && !lit) return 8'hFF;
    if (b.lz && d > 0 && (b.value >> (4 * d)) == 32'd0) return 8'hFF;
    p    = glyph(b.value[4*d +: 4]);
    p[0] = b.dp[d];
    return ~p;
  endfunction

  // One clock edge: advance the model with the inputs the DUT sampled, then
  // compare all outputs shortly after the edge.
  task automatic cycle();
    logic [7:0] e_seg;
    logic [7:0] e_dig;
    int         d;
    bit         wrap;
    bit         lit;
    @(posedge clk);
    if (rst) begin
      k         = 0;
      m_disp    = '0;
      m_pend    = '0;
      m_pending = 1'b0;
      e_seg     = 8'hFF;
      e_dig     = 8'hFE;
    end else begin
      d     = (k / DIV) % ND;
      wrap  = (k % FRAME_CYC) == FRAME_CYC - 1;
      lit   = ((k / FRAME_CYC) / BF) % 2 == 0;
      e_seg = exp_seg(m_disp, d, lit);
      e_dig = ~(8'd1 << d);
      if (wrap && m_pending) m_disp = m_pend;
      if (load) begin
        m_pend    = '{value, dp_mask, blank_mask, blink_mask, lz_en};
        m_pending = 1'b1;
      end else if (wrap) begin
        m_pending = 1'b0;
      end
      k++;
    end
    #1;
    check("o_seg", {24'd0, o_seg}, {24'd0, e_seg});
    check("o_dig", {24'd0, o_dig}, {24'd0, e_dig});
    check("pending", {31'd0, pending}, {31'd0, m_pending});
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp,
                         input logic [7:0] bl, input logic [7:0] bk, input logic lz);
    value = v; dp_mask = dp; blank_mask = bl; blink_mask = bk; lz_en = lz;
    load  = 1'b1;
    cycle();
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0;
    dp_mask = '0; blank_mask = '0; blink_mask = '0; lz_en = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    repeat (2 * FRAME_CYC) cycle();

    // Mid-frame load: old data runs to the frame end, then swaps in.
    repeat (13) cycle();
    do_load(32'h12345678, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (80) cycle();

    do_load(32'h00000A05, 8'h00, 8'h00, 8'h00, 1'b1);
    repeat (2 * FRAME_CYC) cycle();

    // Reset wins over a simultaneous load, then blink from a clean frame count.
    rst = 1'b1;
    do_load(32'hFFFFFFFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    do_load(32'h00000000, 8'h00, 8'h00, 8'h01, 1'b0);
    repeat (6 * FRAME_CYC) cycle();

    // Load exactly on the frame-wrap cycle while another load is pending.
    do_load(32'hAAAA5555, 8'h00, 8'h00, 8'h00, 1'b0);
    while (k % FRAME_CYC != FRAME_CYC - 1) cycle();
    do_load(32'h0000BEEF, 8'h0F, 8'h00, 8'h00, 1'b1);
    check("pending_after_wrap_load", {31'd0, pending}, 32'd1);
    repeat (2 * FRAME_CYC) cycle();

    do_load(32'h12345678, 8'h82, 8'h80, 8'h00, 1'b0);
    repeat (2 * FRAME_CYC) cycle();

    repeat (3000) begin
      rst  = ($urandom_range(0, 399) == 0);
      load = rst || ($urandom_range(0, 19) == 0);
      if (load) begin
        value      = $urandom >> (4 * $urandom_range(0, 7));
        dp_mask    = 8'($urandom);
        blank_mask = 8'($urandom & $urandom & $urandom);
        blink_mask = 8'($urandom & $urandom);
        lz_en      = 1'($urandom);
      end
      cycle();
    end
    rst = 1'b0; load = 1'b0;
    repeat (FRAME_CYC) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
